// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences the shared datapath for R-type, LW, SW, BEQ, ADDI and J,
// stalls on the memory ready handshake and counts retired instructions.
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      instrucao_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             MemtoReg_o,
    output logic             IRWrite_o,
    output logic             RegWrite_o,
    output logic             RegDst_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic [1:0]       PCSource_o,
    output logic [3:0]       state_o,
    output logic             instr_done_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o
);
    // state    | meaning
    // FETCH    | read instruction, PC <= PC+4 when memory is ready
    // DECODE   | latch opcode, branch target into ALUOut
    // MEMADR   | effective address for LW/SW
    // MEMRD    | load data read, waits for mem_ready
    // MEMWB    | load data written to rt
    // MEMWR    | store write, waits for mem_ready
    // EXEC     | R-type ALU operation
    // RTYPE_WB | ALU result written to rd
    // BRANCH   | BEQ compare and conditional PC update
    // JUMP     | PC <= jump target
    // ADDI_EX  | rs + sign-extended immediate
    // ADDI_WB  | ALU result written to rt
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] count_q;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instrucao_i[25:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= FETCH;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            if (instr_done_o) count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        MemtoReg_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegWrite_o    = 1'b0;
        RegDst_o      = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        PCSource_o    = 2'b00;
        instr_done_o  = 1'b0;
        illegal_o     = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
                if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB_o = 2'b11;
                opcode_d  = instrucao_i[31:26];
                case (instrucao_i[31:26])
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            MEMADR, ADDI_EX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                if (state_q == ADDI_EX)     state_d = ADDI_WB;
                else if (opcode_q == OP_SW) state_d = MEMWR;
                else                        state_d = MEMRD;
            end
            MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ready_i) state_d = MEMWB;
            end
            MEMWB: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                MemWrite_o   = 1'b1;
                IorD_o       = 1'b1;
                instr_done_o = mem_ready_i;
                if (mem_ready_i) state_d = FETCH;
            end
            EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b10;
                state_d   = RTYPE_WB;
            end
            RTYPE_WB: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = 1'b1;
                instr_done_o = 1'b1;
                state_d      = FETCH;
            end
            ADDI_WB: begin
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b01;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                instr_done_o  = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                PCWrite_o    = 1'b1;
                PCSource_o   = 2'b10;
                instr_done_o = 1'b1;
                state_d      = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Strobes must never fire while reset is held, even mid-instruction.
        if (reset_i) begin
            PCWrite_o     = 1'b0;
            PCWriteCond_o = 1'b0;
            IRWrite_o     = 1'b0;
            RegWrite_o    = 1'b0;
            MemRead_o     = 1'b0;
            MemWrite_o    = 1'b0;
            instr_done_o  = 1'b0;
            illegal_o     = 1'b0;
        end
    end

    assign state_o       = state_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed vector bench for mips_multicycle_control: per-cycle state/control/count table
// plus a back-to-back BEQ counter wrap sequence.
module tb_mips_multicycle_control;
    localparam int CNT_W = 4;

    logic             clk, reset, mem_ready;
    logic [31:0]      instrucao;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic             IRWrite, RegWrite, RegDst, ALUSrcA, instr_done, illegal;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    mips_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_i(reset), .instrucao_i(instrucao), .mem_ready_i(mem_ready),
        .PCWrite_o(PCWrite), .PCWriteCond_o(PCWriteCond), .IorD_o(IorD),
        .MemRead_o(MemRead), .MemWrite_o(MemWrite), .MemtoReg_o(MemtoReg),
        .IRWrite_o(IRWrite), .RegWrite_o(RegWrite), .RegDst_o(RegDst),
        .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .ALUOp_o(ALUOp),
        .PCSource_o(PCSource), .state_o(state), .instr_done_o(instr_done),
        .illegal_o(illegal), .instr_count_o(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done,illegal}
    function automatic logic [17:0] mk(input logic pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, sa,
                                       input logic [1:0] sb, op, ps, input logic done, ill);
        return {pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, sa, sb, op, ps, done, ill};
    endfunction

    logic [17:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [17:0] ctl, input logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
        vq.push_back(v);
    endtask

    initial begin
        logic [17:0] C_RST_FETCH, C_FETCH_W, C_FETCH_R, C_DECODE, C_DECODE_ILL, C_ADDR;
        logic [17:0] C_MEMRD, C_MEMWB, C_MEMWR_W, C_MEMWR_R, C_RST_MEMWR;
        logic [17:0] C_EXEC, C_RTWB, C_ADDIWB, C_BRANCH, C_JUMP;
        int done_seen;

        C_RST_FETCH  = mk(0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        C_FETCH_W    = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        C_FETCH_R    = mk(1,0,0,1,0,0,1,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        C_DECODE     = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
        C_DECODE_ILL = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,1);
        C_ADDR       = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
        C_MEMRD      = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        C_MEMWB      = mk(0,0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 1,0);
        C_MEMWR_W    = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        C_MEMWR_R    = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
        C_RST_MEMWR  = mk(0,0,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        C_EXEC       = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
        C_RTWB       = mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 1,0);
        C_ADDIWB     = mk(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 1,0);
        C_BRANCH     = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
        C_JUMP       = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0);

        // reset held: strobes forced low in FETCH
        add(1, 6'b000000, 1, 4'd0, C_RST_FETCH, 0);
        // LW, IR altered after DECODE
        add(0, 6'b100011, 1, 4'd0, C_FETCH_R, 0);
        add(0, 6'b100011, 1, 4'd1, C_DECODE,  0);
        add(0, 6'b000000, 1, 4'd2, C_ADDR,    0);
        add(0, 6'b000000, 1, 4'd3, C_MEMRD,   0);
        add(0, 6'b000000, 1, 4'd4, C_MEMWB,   0);
        // SW, two wait cycles in MEMWR
        add(0, 6'b101011, 1, 4'd0, C_FETCH_R, 1);
        add(0, 6'b101011, 1, 4'd1, C_DECODE,  1);
        add(0, 6'b101011, 1, 4'd2, C_ADDR,    1);
        add(0, 6'b101011, 0, 4'd5, C_MEMWR_W, 1);
        add(0, 6'b101011, 0, 4'd5, C_MEMWR_W, 1);
        add(0, 6'b101011, 1, 4'd5, C_MEMWR_R, 1);
        // R-type, three wait cycles in FETCH, IR becomes J during EXEC
        add(0, 6'b000000, 0, 4'd0, C_FETCH_W, 2);
        add(0, 6'b000000, 0, 4'd0, C_FETCH_W, 2);
        add(0, 6'b000000, 0, 4'd0, C_FETCH_W, 2);
        add(0, 6'b000000, 1, 4'd0, C_FETCH_R, 2);
        add(0, 6'b000000, 1, 4'd1, C_DECODE,  2);
        add(0, 6'b000010, 1, 4'd6, C_EXEC,    2);
        add(0, 6'b000010, 1, 4'd7, C_RTWB,    2);
        // ADDI
        add(0, 6'b001000, 1, 4'd0,  C_FETCH_R, 3);
        add(0, 6'b001000, 1, 4'd1,  C_DECODE,  3);
        add(0, 6'b001000, 1, 4'd10, C_ADDR,    3);
        add(0, 6'b001000, 1, 4'd11, C_ADDIWB,  3);
        // J
        add(0, 6'b000010, 1, 4'd0, C_FETCH_R, 4);
        add(0, 6'b000010, 1, 4'd1, C_DECODE,  4);
        add(0, 6'b000010, 1, 4'd9, C_JUMP,    4);
        // illegal opcode: no retire
        add(0, 6'b111111, 1, 4'd0, C_FETCH_R,    5);
        add(0, 6'b111111, 1, 4'd1, C_DECODE_ILL, 5);
        // BEQ
        add(0, 6'b000100, 1, 4'd0, C_FETCH_R, 5);
        add(0, 6'b000100, 1, 4'd1, C_DECODE,  5);
        add(0, 6'b000100, 1, 4'd8, C_BRANCH,  5);
        // SW interrupted by reset in MEMWR
        add(0, 6'b101011, 1, 4'd0, C_FETCH_R,   6);
        add(0, 6'b101011, 1, 4'd1, C_DECODE,    6);
        add(0, 6'b101011, 1, 4'd2, C_ADDR,      6);
        add(1, 6'b101011, 0, 4'd5, C_RST_MEMWR, 6);
        add(0, 6'b000100, 1, 4'd0, C_FETCH_R,   0);

        reset = 1'b1; mem_ready = 1'b0; instrucao = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset = vq[i].rst;
            mem_ready = vq[i].rdy;
            instrucao = {vq[i].op, 26'h0}; 
            #1;
            check($sformatf("v%0d state", i), 32'(state), 32'(vq[i].st));
            check($sformatf("v%0d ctrl", i), 32'(ctrl), 32'(vq[i].ctl));
            check($sformatf("v%0d count", i), 32'(instr_count), 32'(vq[i].cnt));
        end

        // 16 back-to-back BEQ from reset: counter wraps to 0 after 48 cycles
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1; instrucao = {6'b000100, 26'h0};
        done_seen = 0;
        for (int i = 0; i < 48; i++) begin
            #1;
            if (instr_done) done_seen++;
            if (i == 45) check("beq count before wrap", 32'(instr_count), 32'd15);
            @(negedge clk);
        end
        #1;
        check("beq count wrapped", 32'(instr_count), 32'd0);
        check("beq final state", 32'(state), 32'd0);
        check("beq done pulses", 32'(done_seen), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle MIPS control FSM. It sequences the shared datapath (single memory, single ALU, IR, PC, register file) over FETCH/DECODE/EXECUTE/MEM/WB cycles for the instruction subset R-type, LW, SW, BEQ, ADDI and J. It sits beside the datapath and drives all mux selects and write strobes. It stalls on a memory ready handshake and keeps a retired-instruction counter.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk` in 1: the block's one clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `instrucao` in 32: IR output; only bits [31:26] (opcode) are used.
- `mem_ready` in 1: memory completes the current read or write in this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current FSM state (debug).
- `instr_done` out 1: one-cycle pulse on the last cycle of each retired instruction.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Outputs are decoded from `state`. Any output not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal `mem_ready`.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADR and ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1. MemWrite stays high until `mem_ready`.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RTYPE_WB: RegWrite=1, RegDst=1.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
- Opcode latch: in DECODE, `instrucao[31:26]` is registered into an internal opcode register. All later states branch on the latched value, so IR changes after DECODE are ignored.
- Transitions:
  - FETCH → DECODE if `mem_ready`, otherwise stay in FETCH.
  - DECODE on opcode: 100011 or 101011 → MEMADR; 000000 → EXEC; 000100 → BRANCH; 001000 → ADDI_EX; 000010 → JUMP; anything else → FETCH with `illegal`=1 for that DECODE cycle.
  - MEMADR → MEMRD for LW, MEMWR for SW.
  - MEMRD → MEMWB if `mem_ready`, otherwise stay.
  - MEMWR → FETCH if `mem_ready`, otherwise stay.
  - EXEC → RTYPE_WB; ADDI_EX → ADDI_WB.
  - MEMWB, RTYPE_WB, ADDI_WB, BRANCH and JUMP → FETCH.
- `instr_done`=1 in MEMWB, RTYPE_WB, ADDI_WB, BRANCH and JUMP, and in MEMWR when `mem_ready`=1.
- `instr_count` increments by 1 on each edge where `instr_done`=1. It wraps from 2^CNT_W−1 to 0. Illegal opcodes do not count.
- Unused state encodings 12–15 go to FETCH on the next edge, with all outputs 0.

## Timing
- While `reset`=1, every output strobe is forced to 0 combinationally: PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, instr_done, illegal.
- On an edge with `reset`=1: state ← FETCH, opcode register ← 0, instr_count ← 0.
- After reset is released, the first cycle is FETCH with FETCH outputs.
- Reset asserted mid-instruction (e.g. in MEMWR) drops MemWrite in the same cycle and gives FETCH on the next edge. No retire is counted.
- Cycles per instruction with `mem_ready` held at 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle.
- PCWrite and IRWrite pulse exactly once per fetch, regardless of wait states.

## Test plan
- LW with `mem_ready`=1 → `state` sequence 0,1,2,3,4,0; MemtoReg=RegWrite=1 only in state 4; instr_done pulses once; instr_count 0→1.
- SW with `mem_ready` low for 2 cycles in MEMWR → MemWrite high for 3 consecutive cycles; instr_done only on the third; state 0 afterwards.
- FETCH with `mem_ready` low for 3 cycles → MemRead high for 4 cycles; PCWrite and IRWrite high only on the 4th; then DECODE.
- Opcode 111111 → `illegal`=1 in DECODE, back to FETCH; instr_count unchanged; no RegWrite, MemWrite or PCWrite.
- IR changed to 000010 while in EXEC of an R-type → next state is still RTYPE_WB (latched opcode).
- CNT_W=4, 16 back-to-back BEQ (3 cycles each) → instr_count wraps to 0 after 48 cycles. Reset asserted during MEMWR → MemWrite=0 that cycle, state=0 and instr_count=0 next cycle.
